// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch stage: widths, reset PC, NOP encoding
// and the instruction-buffer entry layout.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam int FETCH_DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO of {pc, instr} with flush; when empty the head
// outputs keep showing the last entry that was presented.
module fetch_buffer
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_instr,
  output logic [1:0]      count,
  output logic            valid,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr
);

  fetch_entry_t mem [2];
  fetch_entry_t held;
  fetch_entry_t head;
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign valid   = (count != 2'd0);
  assign do_pop  = pop & valid;
  assign do_push = push & ((count != 2'd2) | do_pop);

  assign head       = valid ? mem[rd_ptr] : held;
  assign head_pc    = head.pc;
  assign head_instr = head.instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      held   <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      // Remember what decode last saw so the outputs hold across empty cycles.
      if (valid) held <= mem[rd_ptr];
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
          wr_ptr      <= ~wr_ptr;
        end
        if (do_pop) rd_ptr <= ~rd_ptr;
        case ({do_push, do_pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC mux and a 2-entry buffer to decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = FETCH_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic            fetch_trap
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [1:0]      count;
  logic            deq;
  logic            enq;
  logic            blocked;

  assign imem_addr = pc;
  assign deq       = out_valid & out_ready;
  assign enq       = ~redirect_valid & ~blocked & ((count != FULL) | deq);

`ifdef FETCH_MISALIGN_CHK_EN
  logic trap;
  logic misaligned;

  assign misaligned = (redirect_target[1:0] != 2'b00);
  assign blocked    = trap;
  assign fetch_trap = trap;

  always_ff @(posedge clk) begin
    if (rst) trap <= 1'b0;
    else if (redirect_valid && misaligned) trap <= 1'b1;
  end

  // Once trapped the PC freezes; a misaligned target never reaches the PC.
  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      if (!misaligned && !trap) pc_next = redirect_target;
    end else if (enq) begin
      pc_next = pc + 32'd4;
    end
  end
`else
  assign blocked    = 1'b0;
  assign fetch_trap = 1'b0;

  always_comb begin
    pc_next = pc;
    if (redirect_valid) pc_next = redirect_target & ~32'h3;
    else if (enq)       pc_next = pc + 32'd4;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  fetch_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (enq),
    .pop        (out_ready),
    .flush      (redirect_valid),
    .push_pc    (pc),
    .push_instr (imem_rdata),
    .count      (count),
    .valid      (out_valid),
    .head_pc    (out_pc),
    .head_instr (out_instr)
  );

  assign out_pc_plus4 = out_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects, PC wrap,
// misaligned target and reset behaviour, checked against hand-computed values.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fetch_trap;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] W0  = 32'h0040_2083;
  localparam logic [31:0] W4  = 32'h0080_2103;
  localparam logic [31:0] W8  = 32'h0011_01B3;
  localparam logic [31:0] W12 = 32'h0030_2623;
  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  always_comb begin
    case (imem_addr)
      32'd0:   imem_rdata = W0;
      32'd4:   imem_rdata = W4;
      32'd8:   imem_rdata = W8;
      32'd12:  imem_rdata = W12;
      default: imem_rdata = NOP;
    endcase
  end

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc_plus4    (out_pc_plus4),
    .fetch_trap      (fetch_trap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instr, ins);
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b0;
    tick();
    rst = 1'b0; out_ready = ready;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b0;
    #2;
    tick();
    head("rst", 1'b0, 32'd0, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_trap", 32'(fetch_trap), 32'd0);

    // 1. streaming with decode always ready
    rst = 1'b0; out_ready = 1'b1;
    chk("t1_addr_c0", imem_addr, 32'd0);
    tick(); head("t1_c1", 1'b1, 32'd0, W0);
    chk("t1_plus4_c1", out_pc_plus4, 32'd4);
    tick(); head("t1_c2", 1'b1, 32'd4, W4);
    tick(); head("t1_c3", 1'b1, 32'd8, W8);
    tick(); head("t1_c4", 1'b1, 32'd12, W12);
    chk("t1_plus4_c4", out_pc_plus4, 32'd16);

    // 2. back-pressure from reset
    do_reset(1'b0);
    tick(); tick();
    chk("t2_addr_full", imem_addr, 32'd8);
    head("t2_full", 1'b1, 32'd0, W0);
    tick();
    chk("t2_addr_hold", imem_addr, 32'd8);
    head("t2_stable", 1'b1, 32'd0, W0);
    out_ready = 1'b1;
    head("t2_pop0", 1'b1, 32'd0, W0);
    tick(); head("t2_pop1", 1'b1, 32'd4, W4);
    tick(); head("t2_pop2", 1'b1, 32'd8, W8);

    // 3. redirect while full
    do_reset(1'b0);
    tick(); tick();
    redirect_valid = 1'b1; redirect_target = 32'd4;
    tick();
    redirect_valid = 1'b0;
    head("t3_flush", 1'b0, 32'd0, W0);
    chk("t3_addr", imem_addr, 32'd4);
    tick(); head("t3_first", 1'b1, 32'd4, W4);

    // 4. deq coincident with redirect
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'd12;
    tick();
    redirect_valid = 1'b0;
    chk("t4_valid_gap", 32'(out_valid), 32'd0);
    tick(); head("t4_next", 1'b1, 32'd12, W12);

    // 5. PC wrap
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); head("t5_top", 1'b1, 32'hFFFF_FFFC, NOP);
    chk("t5_plus4", out_pc_plus4, 32'd0);
    chk("t5_addr_wrap", imem_addr, 32'd0);
    tick(); head("t5_wrap", 1'b1, 32'd0, W0);

    // 6. misaligned redirect target
    redirect_valid = 1'b1; redirect_target = 32'd6;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    chk("t6_trap", 32'(fetch_trap), 32'd1);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_addr", imem_addr, 32'd4);
    tick(); tick(); tick();
    chk("t6_trap_sticky", 32'(fetch_trap), 32'd1);
    chk("t6_valid_held", 32'(out_valid), 32'd0);
    chk("t6_addr_held", imem_addr, 32'd4);
`else
    chk("t6_trap", 32'(fetch_trap), 32'd0);
    chk("t6_addr", imem_addr, 32'd4);
    tick(); head("t6_next", 1'b1, 32'd4, W4);
    tick(); head("t6_more", 1'b1, 32'd8, W8);
`endif

    // reset mid-stream, with a coincident redirect that must lose
    rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'd8;
    tick();
    head("rst2", 1'b0, 32'd0, 32'd0);
    chk("rst2_addr", imem_addr, 32'd0);
    chk("rst2_plus4", out_pc_plus4, 32'd4);
    chk("rst2_trap", 32'(fetch_trap), 32'd0);
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    tick(); head("rst2_resume", 1'b1, 32'd0, W0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
